axi_pcie_tx_arbiter: RTL and testbench

- Packet-granular arbiter sharing the single AXI-stream TX datapath toward the PCIe TRN TX bridge between three requesters:
  - CC: completions for inbound CR requests.
  - RR: outbound master read/write requests.
  - CFG: MSI and config-generated TLPs.
- Sits in front of the enhanced TX path, mirroring how the RX demux splits traffic into CR/CW/RC/CFG.
- Round-robin fairness, plus a starvation guard that forces completions through.

---
 rtl/axi_pcie_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_pcie_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter merging the CC, RR and CFG AXI-stream
// requesters onto the single TX datapath, with a starvation guard for completions.
module axi_pcie_tx_arbiter #(
  parameter int C_DATA_WIDTH      = 64,
  parameter int C_CC_STARVE_LIMIT = 4,
  parameter int TCQ               = 1,
  parameter int STRB_WIDTH        = C_DATA_WIDTH / 8
) (
  input  logic                    com_iclk,
  input  logic                    com_sysrst,
  input  logic                    trn_lnk_up,
  input  logic [C_DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [STRB_WIDTH-1:0]   s_axis_cc_tstrb,
  input  logic                    s_axis_cc_tlast,
  input  logic [3:0]              s_axis_cc_tuser,
  input  logic                    s_axis_cc_tvalid,
  output logic                    s_axis_cc_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_rr_tdata,
  input  logic [STRB_WIDTH-1:0]   s_axis_rr_tstrb,
  input  logic                    s_axis_rr_tlast,
  input  logic [3:0]              s_axis_rr_tuser,
  input  logic                    s_axis_rr_tvalid,
  output logic                    s_axis_rr_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_cfg_tdata,
  input  logic [STRB_WIDTH-1:0]   s_axis_cfg_tstrb,
  input  logic                    s_axis_cfg_tlast,
  input  logic [3:0]              s_axis_cfg_tuser,
  input  logic                    s_axis_cfg_tvalid,
  output logic                    s_axis_cfg_tready,
  output logic [C_DATA_WIDTH-1:0] m_axis_tx_tdata,
  output logic [STRB_WIDTH-1:0]   m_axis_tx_tstrb,
  output logic                    m_axis_tx_tlast,
  output logic [3:0]              m_axis_tx_tuser,
  output logic                    m_axis_tx_tvalid,
  input  logic                    m_axis_tx_tready,
  output logic [2:0]              gnt_onehot,
  output logic [1:0]              o_dbg_state,
  output logic [3:0]              o_dbg_starve_cnt
);

  // Handshake: a beat transfers on a rising edge where tvalid & tready are both
  // high; tvalid never waits on tready, and payload holds while valid & !ready.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CC  = 2'd1,
    GNT_RR  = 2'd2,
    GNT_CFG = 2'd3
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(C_CC_STARVE_LIMIT);
  // TCQ only models clock-to-Q in older flows; it folds into the saturation constant.
  localparam logic [3:0] LP_SAT   = 4'(15 + 0 * TCQ);

  state_t     r_state, w_state_nxt, w_winner;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [3:0] r_starve_cnt, w_starve_nxt;
  logic       r_cc_seen, w_cc_seen_nxt;
  logic [2:0] w_req;
  logic       w_src_valid, w_src_last, w_last_hs;

  assign w_req = {s_axis_cfg_tvalid, s_axis_rr_tvalid, s_axis_cc_tvalid};

  // Rotating priority from r_ptr, overridden when CC has waited too long.
  always_comb begin
    w_winner = GNT_CC;
    if (w_req[0] && (r_starve_cnt >= LP_LIMIT)) begin
      w_winner = GNT_CC;
    end else begin
      case (r_ptr)
        2'd1: begin
          if (w_req[1])      w_winner = GNT_RR;
          else if (w_req[2]) w_winner = GNT_CFG;
          else               w_winner = GNT_CC;
        end
        2'd2: begin
          if (w_req[2])      w_winner = GNT_CFG;
          else if (w_req[0]) w_winner = GNT_CC;
          else               w_winner = GNT_RR;
        end
        default: begin
          if (w_req[0])      w_winner = GNT_CC;
          else if (w_req[1]) w_winner = GNT_RR;
          else               w_winner = GNT_CFG;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_starve_nxt      = r_starve_cnt;
    w_cc_seen_nxt     = r_cc_seen;
    m_axis_tx_tdata   = '0;
    m_axis_tx_tstrb   = '0;
    m_axis_tx_tlast   = 1'b0;
    m_axis_tx_tuser   = '0;
    m_axis_tx_tvalid  = 1'b0;
    s_axis_cc_tready  = 1'b0;
    s_axis_rr_tready  = 1'b0;
    s_axis_cfg_tready = 1'b0;
    gnt_onehot        = 3'b000;
    w_src_valid       = 1'b0;
    w_src_last        = 1'b0;
    case (r_state)
      IDLE: begin
        w_cc_seen_nxt = 1'b0;
        if (trn_lnk_up && (|w_req)) w_state_nxt = w_winner;
      end
      GNT_CC: begin
        m_axis_tx_tdata  = s_axis_cc_tdata;
        m_axis_tx_tstrb  = s_axis_cc_tstrb;
        m_axis_tx_tlast  = s_axis_cc_tlast;
        m_axis_tx_tuser  = s_axis_cc_tuser;
        m_axis_tx_tvalid = s_axis_cc_tvalid;
        s_axis_cc_tready = m_axis_tx_tready;
        gnt_onehot       = 3'b001;
        w_src_valid      = s_axis_cc_tvalid;
        w_src_last       = s_axis_cc_tlast;
      end
      GNT_RR: begin
        m_axis_tx_tdata  = s_axis_rr_tdata;
        m_axis_tx_tstrb  = s_axis_rr_tstrb;
        m_axis_tx_tlast  = s_axis_rr_tlast;
        m_axis_tx_tuser  = s_axis_rr_tuser;
        m_axis_tx_tvalid = s_axis_rr_tvalid;
        s_axis_rr_tready = m_axis_tx_tready;
        gnt_onehot       = 3'b010;
        w_src_valid      = s_axis_rr_tvalid;
        w_src_last       = s_axis_rr_tlast;
        w_cc_seen_nxt    = r_cc_seen | s_axis_cc_tvalid;
      end
      GNT_CFG: begin
        m_axis_tx_tdata   = s_axis_cfg_tdata;
        m_axis_tx_tstrb   = s_axis_cfg_tstrb;
        m_axis_tx_tlast   = s_axis_cfg_tlast;
        m_axis_tx_tuser   = s_axis_cfg_tuser;
        m_axis_tx_tvalid  = s_axis_cfg_tvalid;
        s_axis_cfg_tready = m_axis_tx_tready;
        gnt_onehot        = 3'b100;
        w_src_valid       = s_axis_cfg_tvalid;
        w_src_last        = s_axis_cfg_tlast;
        w_cc_seen_nxt     = r_cc_seen | s_axis_cc_tvalid;
      end
    endcase

    w_last_hs = w_src_valid & m_axis_tx_tready & w_src_last;
    if (w_last_hs) begin
      w_state_nxt   = IDLE;
      w_cc_seen_nxt = 1'b0;
      case (r_state)
        GNT_CC:  w_ptr_nxt = 2'd1;
        GNT_RR:  w_ptr_nxt = 2'd2;
        default: w_ptr_nxt = 2'd0;
      endcase
      if (r_state == GNT_CC) begin
        w_starve_nxt = 4'd0;
      end else if (r_cc_seen || s_axis_cc_tvalid) begin
        w_starve_nxt = (r_starve_cnt == LP_SAT) ? r_starve_cnt : r_starve_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge com_iclk) begin
    if (com_sysrst) begin
      r_state      <= IDLE;
      r_ptr        <= 2'd0;
      r_starve_cnt <= 4'd0;
      r_cc_seen    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_cc_seen    <= w_cc_seen_nxt;
    end
  end

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_axi_pcie_tx_arbiter.sv
// Directed bench for axi_pcie_tx_arbiter: reset, round-robin, starvation guard,
// backpressure, link-down and mid-packet reset, with an output-beat scoreboard.
module tb_axi_pcie_tx_arbiter;

  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          lnk_up;
  logic [DW-1:0] cc_tdata, rr_tdata, cfg_tdata, m_tdata;
  logic [SW-1:0] cc_tstrb, rr_tstrb, cfg_tstrb, m_tstrb;
  logic          cc_tlast, rr_tlast, cfg_tlast, m_tlast;
  logic [3:0]    cc_tuser, rr_tuser, cfg_tuser, m_tuser;
  logic          cc_tvalid, rr_tvalid, cfg_tvalid, m_tvalid;
  logic          cc_tready, rr_tready, cfg_tready, m_tready;
  logic [2:0]    gnt;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_starve;

  axi_pcie_tx_arbiter #(
    .C_DATA_WIDTH      (DW),
    .C_CC_STARVE_LIMIT (2)
  ) dut (
    .com_iclk          (clk),
    .com_sysrst        (rst),
    .trn_lnk_up        (lnk_up),
    .s_axis_cc_tdata   (cc_tdata),
    .s_axis_cc_tstrb   (cc_tstrb),
    .s_axis_cc_tlast   (cc_tlast),
    .s_axis_cc_tuser   (cc_tuser),
    .s_axis_cc_tvalid  (cc_tvalid),
    .s_axis_cc_tready  (cc_tready),
    .s_axis_rr_tdata   (rr_tdata),
    .s_axis_rr_tstrb   (rr_tstrb),
    .s_axis_rr_tlast   (rr_tlast),
    .s_axis_rr_tuser   (rr_tuser),
    .s_axis_rr_tvalid  (rr_tvalid),
    .s_axis_rr_tready  (rr_tready),
    .s_axis_cfg_tdata  (cfg_tdata),
    .s_axis_cfg_tstrb  (cfg_tstrb),
    .s_axis_cfg_tlast  (cfg_tlast),
    .s_axis_cfg_tuser  (cfg_tuser),
    .s_axis_cfg_tvalid (cfg_tvalid),
    .s_axis_cfg_tready (cfg_tready),
    .m_axis_tx_tdata   (m_tdata),
    .m_axis_tx_tstrb   (m_tstrb),
    .m_axis_tx_tlast   (m_tlast),
    .m_axis_tx_tuser   (m_tuser),
    .m_axis_tx_tvalid  (m_tvalid),
    .m_axis_tx_tready  (m_tready),
    .gnt_onehot        (gnt),
    .o_dbg_state       (dbg_state),
    .o_dbg_starve_cnt  (dbg_starve)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Source models: packet/beat counters per requester (0 CC, 1 RR, 2 CFG)
  int pkt[3];
  int beat[3];
  int len[3];
  int max_pkt[3];
  int n_checks = 0;
  int n_errors = 0;
  int n_tx_beats = 0;
  logic [DW-1:0] exp_q[$];

  function automatic logic [DW-1:0] mk_data(input int s, input int p, input int b);
    return {4'hA, 4'(s), 24'(p), 32'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_srcs();
    cc_tvalid  = (pkt[0] < max_pkt[0]);
    cc_tdata   = mk_data(0, pkt[0], beat[0]);
    cc_tlast   = (beat[0] == len[0] - 1);
    cc_tstrb   = '1;
    cc_tuser   = 4'd1;
    rr_tvalid  = (pkt[1] < max_pkt[1]);
    rr_tdata   = mk_data(1, pkt[1], beat[1]);
    rr_tlast   = (beat[1] == len[1] - 1);
    rr_tstrb   = '1;
    rr_tuser   = 4'd2;
    cfg_tvalid = (pkt[2] < max_pkt[2]);
    cfg_tdata  = mk_data(2, pkt[2], beat[2]);
    cfg_tlast  = (beat[2] == len[2] - 1);
    cfg_tstrb  = '1;
    cfg_tuser  = 4'd3;
  endtask

  // One clock: sample handshakes before the edge, advance sources after it.
  task automatic step();
    logic [2:0]    hs;
    logic          mhs;
    logic [DW-1:0] mdata;
    drive_srcs();
    #1;
    hs    = {cfg_tvalid & cfg_tready, rr_tvalid & rr_tready, cc_tvalid & cc_tready};
    mhs   = m_tvalid & m_tready;
    mdata = m_tdata;
    @(posedge clk);
    #1;
    if (mhs === 1'b1) begin
      n_tx_beats++;
      chk("tx_beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("tx_data", mdata, exp_q.pop_front());
    end
    for (int s = 0; s < 3; s++) begin
      if (hs[s] === 1'b1) begin
        if (beat[s] == len[s] - 1) begin
          beat[s] = 0;
          pkt[s]++;
        end else begin
          beat[s]++;
        end
      end
    end
    drive_srcs();
    #1;
  endtask

  int   st_gnt[13] = '{2, 0, 4, 0, 2, 0, 1, 1, 0, 2, 0, 4, 0};
  logic bp_pat[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [DW-1:0] prev;
    int            beats0;
    logic [2:0]    eg;
    rst      = 1'b1;
    lnk_up   = 1'b1;
    m_tready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      pkt[s] = 0; beat[s] = 0; len[s] = 2; max_pkt[s] = 2;
    end
    drive_srcs();

    // Reset held 3 cycles with every requester valid
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_treadys", 64'({cfg_tready, rr_tready, cc_tready}), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    end
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_starve", 64'(dbg_starve), 64'd0);
    rst = 1'b0;
    #1;
    chk("release_idle_gnt", 64'(gnt), 64'd0);

    // Round-robin: 2-beat packets, two per requester, order CC,RR,CFG
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 3; s++)
        for (int b = 0; b < 2; b++) exp_q.push_back(mk_data(s, p, b));
    for (int k = 0; k < 18; k++) begin
      step();
      eg = (k % 3 == 2) ? 3'b000 : (3'b001 << ((k / 3) % 3));
      chk("rr_gnt", 64'(gnt), 64'(eg));
      if (k % 3 != 2) begin
        chk("rr_tuser", 64'(m_tuser), 64'((k / 3) % 3 + 1));
        chk("rr_tstrb", 64'(m_tstrb), 64'hFF);
      end
    end
    chk("rr_starve_end", 64'(dbg_starve), 64'd0);
    chk("rr_queue_empty", 64'(exp_q.size()), 64'd0);

    // Starvation guard (limit 2): CC pulses so it is skipped once, then forced
    len[1] = 1; len[2] = 1; len[0] = 2;
    max_pkt[1] = pkt[1] + 3;
    max_pkt[2] = pkt[2] + 2;
    exp_q.push_back(mk_data(1, 2, 0));
    exp_q.push_back(mk_data(2, 2, 0));
    exp_q.push_back(mk_data(1, 3, 0));
    exp_q.push_back(mk_data(0, 2, 0));
    exp_q.push_back(mk_data(0, 2, 1));
    exp_q.push_back(mk_data(1, 4, 0));
    exp_q.push_back(mk_data(2, 3, 0));
    for (int i = 0; i < 13; i++) begin
      step();
      chk("starve_gnt", 64'(gnt), 64'(st_gnt[i]));
      if (i == 1) chk("starve_cnt1", 64'(dbg_starve), 64'd1);
      if (i == 3) chk("starve_cnt2", 64'(dbg_starve), 64'd2);
      if (i == 5) chk("starve_cnt3", 64'(dbg_starve), 64'd3);
      if (i == 8) chk("starve_cnt_clr", 64'(dbg_starve), 64'd0);
      if (i == 0 || i == 4) max_pkt[0] = pkt[0] + 1;
      if (i == 3) max_pkt[0] = pkt[0];
    end
    chk("starve_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure on a 4-beat CFG packet
    len[2] = 4;
    max_pkt[2] = pkt[2] + 1;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk_data(2, 4, b));
    step();
    chk("bp_gnt_start", 64'(gnt), 64'b100);
    beats0 = n_tx_beats;
    for (int i = 0; i < 7; i++) begin
      m_tready = bp_pat[i];
      prev = m_tdata;
      if (i == 6) chk("bp_tlast", 64'(m_tlast), 64'd1);
      step();
      if (!bp_pat[i]) chk("bp_hold", m_tdata, prev);
      chk("bp_gnt", 64'(gnt), (i == 6) ? 64'd0 : 64'b100);
    end
    m_tready = 1'b1;
    chk("bp_beats", 64'(n_tx_beats - beats0), 64'd4);

    // Link drops during beat 2 of a 3-beat RR packet while CC waits
    len[1] = 3;
    max_pkt[1] = pkt[1] + 1;
    for (int b = 0; b < 3; b++) exp_q.push_back(mk_data(1, 5, b));
    exp_q.push_back(mk_data(0, 3, 0));
    step();
    chk("ld_gnt_rr", 64'(gnt), 64'b010);
    len[0] = 1;
    max_pkt[0] = pkt[0] + 1;
    step();
    chk("ld_gnt_rr_b1", 64'(gnt), 64'b010);
    lnk_up = 1'b0;
    step();
    chk("ld_gnt_held", 64'(gnt), 64'b010);
    step();
    chk("ld_rr_done", 64'(gnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_idle_gnt", 64'(gnt), 64'd0);
      chk("ld_idle_tvalid", 64'(m_tvalid), 64'd0);
    end
    lnk_up = 1'b1;
    step();
    chk("ld_cc_gnt", 64'(gnt), 64'b001);
    step();
    chk("ld_cc_done", 64'(gnt), 64'd0);
    chk("ld_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset during beat 2 of a 4-beat CC packet
    len[0] = 4;
    max_pkt[0] = pkt[0] + 1;
    exp_q.push_back(mk_data(0, 4, 0));
    exp_q.push_back(mk_data(0, 4, 1));
    step();
    chk("mr_gnt_cc", 64'(gnt), 64'b001);
    step();
    chk("mr_gnt_cc_b1", 64'(gnt), 64'b001);
    rst = 1'b1;
    step();
    chk("mr_gnt", 64'(gnt), 64'd0);
    chk("mr_cc_tready", 64'(cc_tready), 64'd0);
    chk("mr_m_tvalid", 64'(m_tvalid), 64'd0);
    max_pkt[0] = pkt[0];
    beat[0] = 0;
    step();
    rst = 1'b0;
    step();
    chk("mr_post_gnt", 64'(gnt), 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
